// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: round-robin producer arbiter into a shared FIFO, drained through a registered valid/ready stream
module fifo_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      fifo_push,
  output logic [DATA_W-1:0]         fifo_din,
  output logic                      fifo_pop,
  input  logic [DATA_W-1:0]         fifo_dout,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic                      m_valid,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_ready
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, sel;
  logic hit, take;
  // first asserted requester at or after rr_ptr, wrapping modulo NUM_REQ; suppressed when full or in reset
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        hit = 1'b1;
        sel = PW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    hit = hit && !fifo_full && !rst;
  end
  assign gnt = hit ? NUM_REQ'(1) << sel : '0;
  assign fifo_push = hit;
  assign fifo_din = hit ? req_data[sel*DATA_W +: DATA_W] : '0;
  // pointer moves just past the granted requester so it gets lowest priority next
  always_ff @(posedge clk)
    if (rst) rr_ptr <= '0;
    else if (hit) rr_ptr <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
  // pop whenever the output stage is free (idle or being accepted) and the FIFO has data
  always_comb begin
    take = state == IDLE || (state == HOLD && m_ready);
    fifo_pop = !rst && take && !fifo_empty;
    state_nxt = take ? (fifo_empty ? IDLE : LOAD) : state == LOAD ? HOLD : state == HOLD ? HOLD : IDLE;
  end
  // LOAD captures the word that arrives one cycle after the pop; an accept in HOLD empties the stage
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      m_valid <= 1'b0;
      m_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        m_valid <= 1'b1;
        m_data <= fifo_dout;
      end else if (state == HOLD && m_ready) m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fifo_share_ctrl.sv
// tb_fifo_share_ctrl: directed checks of arbitration, read FSM timing, full stall, backpressure and reset
module tb_fifo_share_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] gnt;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty, m_valid, m_ready = 1'b0;
  logic [7:0] fifo_din, fifo_dout, m_data;
  logic [7:0] mem [128];
  logic [6:0] wp, rp;
  int cnt;
  int checks = 0;
  int errors = 0;
  int ovf = 0;
  int udf = 0;
  logic [7:0] rxq [$];

  fifo_share_ctrl #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_push(fifo_push), .fifo_din(fifo_din), .fifo_pop(fifo_pop),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  assign fifo_full = cnt == 128;
  assign fifo_empty = cnt == 0;

  always @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= 0;
      fifo_dout <= '0;
    end else begin
      if (fifo_push && cnt == 128) ovf <= ovf + 1;
      if (fifo_pop && cnt == 0) udf <= udf + 1;
      if (fifo_push && cnt < 128) begin
        mem[wp] <= fifo_din;
        wp <= wp + 1'b1;
      end
      if (fifo_pop && cnt > 0) begin
        fifo_dout <= mem[rp];
        rp <= rp + 1'b1;
      end else fifo_dout <= '0;
      cnt <= cnt + ((fifo_push && cnt < 128) ? 1 : 0) - ((fifo_pop && cnt > 0) ? 1 : 0);
    end

  always @(negedge clk)
    if (!rst && m_valid && m_ready) rxq.push_back(m_data);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    rxq.delete();
  endtask

  task automatic drain(input int n, input string name);
    int i = 0;
    while (rxq.size() < n && i < 2000) begin
      tick();
      i++;
    end
    checks++;
    if (rxq.size() != n) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", name, rxq.size(), n);
    end
  endtask

  task automatic wait_valid(input int lim);
    int i = 0;
    @(negedge clk);
    while (!m_valid && i < lim) begin
      tick();
      @(negedge clk);
      i++;
    end
    checks++;
    if (!m_valid) begin
      errors++;
      $display("FAIL wait_valid m_valid=%b want 1", m_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'hF;
    req_data = 32'h44332211;
    m_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks += 5;
    if (gnt !== 4'b0) begin errors++; $display("FAIL rst_gnt got %b want 0000", gnt); end
    if (fifo_push !== 1'b0) begin errors++; $display("FAIL rst_push got %b want 0", fifo_push); end
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL rst_pop got %b want 0", fifo_pop); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
    if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data got %h want 00", m_data); end
    tick();
    rst = 1'b0;
    req = '0;
    rxq.delete();
  endtask

  task automatic test_single;
    m_ready = 1'b1;
    req = 4'b0001;
    req_data = 32'h000000A5;
    @(negedge clk);
    checks += 3;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", gnt); end
    if (fifo_push !== 1'b1) begin errors++; $display("FAIL single_push got %b want 1", fifo_push); end
    if (fifo_din !== 8'hA5) begin errors++; $display("FAIL single_din got %h want a5", fifo_din); end
    tick();
    req = '0;
    @(negedge clk);
    checks++;
    if (fifo_pop !== 1'b1) begin errors++; $display("FAIL single_pop got %b want 1", fifo_pop); end
    tick();
    @(negedge clk);
    checks += 2;
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL single_load_pop got %b want 0", fifo_pop); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL single_load_valid got %b want 0", m_valid); end
    tick();
    @(negedge clk);
    checks += 2;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", m_valid); end
    if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", m_data); end
    tick();
    @(negedge clk);
    checks += 2;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", m_valid); end
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL single_idle_pop got %b want 0", fifo_pop); end
    tick();
  endtask

  task automatic test_round_robin;
    logic [3:0] e;
    do_reset();
    m_ready = 1'b1;
    req = 4'hF;
    req_data = 32'h13121110;
    for (int c = 0; c < 8; c++) begin
      e = 4'b0001 << (c % 4);
      @(negedge clk);
      checks += 2;
      if (gnt !== e) begin errors++; $display("FAIL rr_gnt%0d got %b want %b", c, gnt, e); end
      if (fifo_din !== 8'(8'h10 + c % 4)) begin errors++; $display("FAIL rr_din%0d got %h want %h", c, fifo_din, 8'h10 + c % 4); end
      tick();
    end
    req = '0;
    drain(8, "rr");
    for (int i = 0; i < 8 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== 8'(8'h10 + i % 4)) begin errors++; $display("FAIL rr_rx%0d got %h want %h", i, rxq[i], 8'h10 + i % 4); end
    end
  endtask

  task automatic test_ptr_wrap;
    logic [7:0] e [3];
    e = '{8'h22, 8'h20, 8'h22};
    do_reset();
    m_ready = 1'b1;
    req_data = 32'h23222120;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_pre got %b want 0100", gnt); end
    tick();
    req = 4'b0101;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 got %b want 0001", gnt); end
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_gnt2 got %b want 0100", gnt); end
    tick();
    req = '0;
    drain(3, "wrap");
    for (int i = 0; i < 3 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== e[i]) begin errors++; $display("FAIL wrap_rx%0d got %h want %h", i, rxq[i], e[i]); end
    end
  endtask

  task automatic test_full_stall;
    int n = 0;
    logic [7:0] d = '0;
    logic got = 1'b0;
    do_reset();
    m_ready = 1'b0;
    req = 4'b0010;
    for (int c = 0; c < 300; c++) begin
      req_data[15:8] = d;
      @(negedge clk);
      if (fifo_full) break;
      if (gnt[1]) begin
        n++;
        d++;
      end
      tick();
    end
    checks += 2;
    if (!fifo_full) begin errors++; $display("FAIL full_reached got %b want 1", fifo_full); end
    if (n != 129) begin errors++; $display("FAIL full_fill_count got %0d want 129", n); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        tick();
        @(negedge clk);
      end
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL full_stall%0d got %b want 0000", c, gnt); end
    end
    tick();
    m_ready = 1'b1;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      got = gnt == 4'b0010;
      tick();
    end
    req = '0;
    checks++;
    if (!got) begin errors++; $display("FAIL full_resume got %b want 1", got); end
    drain(n + 1, "full");
    for (int i = 0; i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== 8'(i)) begin errors++; $display("FAIL full_rx%0d got %h want %h", i, rxq[i], 8'(i)); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    m_ready = 1'b0;
    req = 4'b0001;
    req_data = 32'h00000040;
    tick();
    req_data = 32'h00000041;
    tick();
    req = '0;
    wait_valid(10);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        tick();
        @(negedge clk);
      end
      checks += 3;
      if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %b want 1", c, m_valid); end
      if (m_data !== 8'h40) begin errors++; $display("FAIL bp_data%0d got %h want 40", c, m_data); end
      if (fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_pop%0d got %b want 0", c, fifo_pop); end
    end
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_pop !== 1'b1) begin errors++; $display("FAIL bp_accept_pop got %b want 1", fifo_pop); end
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_load_valid got %b want 0", m_valid); end
    tick();
    @(negedge clk);
    checks += 2;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %b want 1", m_valid); end
    if (m_data !== 8'h41) begin errors++; $display("FAIL bp_next_data got %h want 41", m_data); end
    tick();
    tick();
  endtask

  task automatic test_reset_hold;
    do_reset();
    m_ready = 1'b0;
    req = 4'b0001;
    req_data = 32'h00000050;
    tick();
    req_data = 32'h00000051;
    tick();
    req = '0;
    wait_valid(10);
    tick();
    rst = 1'b1;
    req = 4'b0001;
    req_data = 32'h00000052;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL rh_rst_gnt got %b want 0000", gnt); end
    tick();
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    checks += 3;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got %b want 0", m_valid); end
    if (m_data !== 8'h00) begin errors++; $display("FAIL rh_data got %h want 00", m_data); end
    if (gnt !== 4'b0000) begin errors++; $display("FAIL rh_gnt got %b want 0000", gnt); end
    tick();
    rxq.delete();
    m_ready = 1'b1;
    req = 4'b0001;
    req_data = 32'h00000053;
    tick();
    req = '0;
    drain(1, "rh");
    if (rxq.size() > 0) begin
      checks++;
      if (rxq[0] !== 8'h53) begin errors++; $display("FAIL rh_rx got %h want 53", rxq[0]); end
    end
    tick();
    tick();
    checks++;
    if (rxq.size() != 1) begin errors++; $display("FAIL rh_extra got %0d want 1", rxq.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_full_stall();
    test_backpressure();
    test_reset_hold();
    checks += 2;
    if (ovf != 0) begin errors++; $display("FAIL push_while_full got %0d want 0", ovf); end
    if (udf != 0) begin errors++; $display("FAIL pop_while_empty got %0d want 0", udf); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
